// File: rtl/uart_imem_loader.sv
// UART byte receiver that packs little-endian 32-bit words into instruction-memory writes.
// Optional even-parity framing is enabled by defining UART_PARITY_EN (default build is 8N1).
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 12
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        prog,
    input  logic        rx,
    output logic        imem_prog_ena,
    output logic        imem_wea,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] word_count,
    output logic [2:0]  dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_sync_q, rx_sync_d;
    logic               prog_q, prog_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        word_q, word_d;
    logic               wea_q, wea_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [31:0]        din_q, din_d;
    logic [15:0]        word_count_q, word_count_d;
    logic               frame_err_q, frame_err_d;
    logic               byte_ok;
`ifdef UART_PARITY_EN
    logic               par_err_q, par_err_d;
`endif

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            prog_q       <= 1'b0;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            wea_q        <= 1'b0;
            addr_q       <= '0;
            wr_addr_q    <= '0;
            din_q        <= '0;
            word_count_q <= '0;
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            prog_q       <= prog_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            wea_q        <= wea_d;
            addr_q       <= addr_d;
            wr_addr_q    <= wr_addr_d;
            din_q        <= din_d;
            word_count_q <= word_count_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        rx_meta_d    = rx;
        rx_sync_d    = rx_meta_q;
        prog_d       = prog;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        wea_d        = 1'b0;
        addr_d       = addr_q;
        wr_addr_d    = wr_addr_q;
        din_d        = din_q;
        word_count_d = word_count_q;
        frame_err_d  = 1'b0;
        byte_ok      = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d    = par_err_q;
`endif

        // A new programming session always starts writing at address 0.
        if (prog && !prog_q) begin
            wr_addr_d    = '0;
            byte_idx_d   = '0;
            word_count_d = '0;
        end

        if (!prog) begin
            state_d    = S_IDLE;
            byte_idx_d = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_sync_q) state_d = S_START;
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = rx_sync_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d     = '0;
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_PARITY_EN
                        if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
                        if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d       = '0;
                        par_err_d   = (^shift_q) ^ rx_sync_q;
                        frame_err_d = (^shift_q) ^ rx_sync_q;
                        state_d     = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        if (!rx_sync_q) frame_err_d = 1'b1;
`ifdef UART_PARITY_EN
                        byte_ok = rx_sync_q && !par_err_q;
`else
                        byte_ok = rx_sync_q;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Bytes 0..2 are parked; byte 3 completes the word and schedules the strobe.
        if (byte_ok) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
                2'd0: word_d[7:0]   = shift_q;
                2'd1: word_d[15:8]  = shift_q;
                2'd2: word_d[23:16] = shift_q;
                default: begin
                    wea_d     = 1'b1;
                    din_d     = {shift_q, word_q};
                    addr_d    = wr_addr_q;
                    wr_addr_d = wr_addr_q + ADDR_W'(4);
                    if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
                end
            endcase
        end
    end

    assign imem_prog_ena = prog_q;
    assign imem_wea      = wea_q;
    assign imem_addr     = {{(32 - ADDR_W){1'b0}}, addr_q};
    assign imem_din      = din_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_err     = frame_err_q;
    assign word_count    = word_count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader at 16 clocks per bit; a second instance with a
// 4-bit address space exercises the address wrap cheaply.
module tb_uart_imem_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        Rst;
    logic        prog;
    logic        rx;
    logic        imem_prog_ena, imem_wea, busy, frame_err;
    logic [31:0] imem_addr, imem_din;
    logic [15:0] word_count;
    logic [2:0]  dbg_state;
    logic        w_prog_ena, w_wea, w_busy, w_frame_err;
    logic [31:0] w_addr, w_din;
    logic [15:0] w_word_count;
    logic [2:0]  w_dbg_state;

    always #5 clk = ~clk;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(12)) dut (
        .clk(clk), .Rst(Rst), .prog(prog), .rx(rx),
        .imem_prog_ena(imem_prog_ena), .imem_wea(imem_wea),
        .imem_addr(imem_addr), .imem_din(imem_din),
        .busy(busy), .frame_err(frame_err), .word_count(word_count),
        .dbg_state(dbg_state)
    );

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(4)) dut_w (
        .clk(clk), .Rst(Rst), .prog(prog), .rx(rx),
        .imem_prog_ena(w_prog_ena), .imem_wea(w_wea),
        .imem_addr(w_addr), .imem_din(w_din),
        .busy(w_busy), .frame_err(w_frame_err), .word_count(w_word_count),
        .dbg_state(w_dbg_state)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wexp_q[$];
    int          strobe_cnt = 0;
    int          fe_cnt     = 0;
    int          busy_run   = 0;
    int          busy_max   = 0;
    bit          w_watch    = 1'b0;
    int          s0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard and event counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_wea) begin
            strobe_cnt++;
            if (exp_q.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
            else chk("strobe", {imem_addr, imem_din}, exp_q.pop_front());
        end
        if (w_watch && w_wea) begin
            if (wexp_q.size() == 0) chk("wrap_unexpected_strobe", 64'd1, 64'd0);
            else chk("wrap_strobe", {w_addr, w_din}, wexp_q.pop_front());
        end
        if (frame_err) fe_cnt++;
        if (busy) begin
            busy_run++;
            if (busy_run > busy_max) busy_max = busy_run;
        end else begin
            busy_run = 0;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop_bit;
        wait_cyc(CPB);
        rx = 1'b1;
        wait_cyc(8);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic push(input int addr, input logic [31:0] din);
        exp_q.push_back({32'(addr), din});
    endtask

    task automatic prog_restart();
        prog = 1'b0;
        wait_cyc(4);
        prog = 1'b1;
        wait_cyc(2);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_wea"},        64'(imem_wea), 64'd0);
        chk({pfx, "_prog_ena"},   64'(imem_prog_ena), 64'd0);
        chk({pfx, "_addr"},       64'(imem_addr), 64'd0);
        chk({pfx, "_din"},        64'(imem_din), 64'd0);
        chk({pfx, "_word_count"}, 64'(word_count), 64'd0);
        chk({pfx, "_busy"},       64'(busy), 64'd0);
        chk({pfx, "_frame_err"},  64'(frame_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rx   = 1'b1;
        prog = 1'b0;
        Rst  = 1'b1;
        wait_cyc(3);
        check_reset_outputs("reset");
        Rst = 1'b0;
        wait_cyc(2);
        prog = 1'b1;
        wait_cyc(1);
        chk("prog_ena_follows", 64'(imem_prog_ena), 64'd1);

        // Two words from the first programming session.
        push(0, 32'h0000_0013);
        push(4, 32'h0010_0093);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        wait_cyc(4);
        chk("t1_word_count", 64'(word_count), 64'd2);
        chk("t1_pending", 64'(exp_q.size()), 64'd0);
        chk("t1_no_frame_err", 64'(fe_cnt), 64'd0);

        // Stop bit held low: one error pulse, byte dropped.
        prog_restart();
        fe_cnt = 0;
        send_byte(8'h55, 1'b0);
        chk("t2_frame_err_once", 64'(fe_cnt), 64'd1);
        push(0, 32'h0403_0201);
        send_word(32'h0403_0201);
        wait_cyc(4);
        chk("t2_pending", 64'(exp_q.size()), 64'd0);
        chk("t2_word_count", 64'(word_count), 64'd1);

        // Short low glitch on rx.
        prog_restart();
        fe_cnt   = 0;
        busy_max = 0;
        s0       = strobe_cnt;
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(30);
        chk("t3_busy_le8", 64'(busy_max <= 8), 64'd1);
        chk("t3_busy_seen", 64'(busy_max > 0), 64'd1);
        chk("t3_no_frame_err", 64'(fe_cnt), 64'd0);
        chk("t3_no_strobe", 64'(strobe_cnt - s0), 64'd0);
        chk("t3_idle", 64'(busy), 64'd0);

        // prog dropped mid-word: partial word discarded.
        prog_restart();
        s0 = strobe_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        prog = 1'b0;
        wait_cyc(2);
        chk("t4_prog_ena_low", 64'(imem_prog_ena), 64'd0);
        chk("t4_wea_low", 64'(imem_wea), 64'd0);
        wait_cyc(2);
        prog = 1'b1;
        wait_cyc(2);
        push(0, 32'hDDCC_BBAA);
        send_word(32'hDDCC_BBAA);
        wait_cyc(4);
        chk("t4_single_strobe", 64'(strobe_cnt - s0), 64'd1);
        chk("t4_pending", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a frame.
        prog_restart();
        push(0, 32'hCAFE_0001);
        push(4, 32'hCAFE_0002);
        send_word(32'hCAFE_0001);
        send_word(32'hCAFE_0002);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rx = 1'b0;
        wait_cyc(CPB);
        rx = 1'b1;
        wait_cyc(CPB + CPB / 2);
        chk("t5_busy_before_rst", 64'(busy), 64'd1);
        Rst = 1'b1;
        wait_cyc(1);
        check_reset_outputs("t5_rst");
        Rst = 1'b0;
        wait_cyc(200);
        push(0, 32'h4433_2211);
        send_word(32'h4433_2211);
        wait_cyc(4);
        chk("t5_pending", 64'(exp_q.size()), 64'd0);
        chk("t5_word_count", 64'(word_count), 64'd1);

        // Address wrap on the 4-bit instance; the wide instance keeps counting up.
        prog_restart();
        w_watch = 1'b1;
        for (int n = 0; n < 5; n++) begin
            w = {8'(4*n + 3), 8'(4*n + 2), 8'(4*n + 1), 8'(4*n)};
            push(4*n, w);
            wexp_q.push_back({32'((4*n) % 16), w});
            send_word(w);
        end
        wait_cyc(4);
        w_watch = 1'b0;
        chk("t6_pending", 64'(exp_q.size()), 64'd0);
        chk("t6_wrap_pending", 64'(wexp_q.size()), 64'd0);
        chk("t6_word_count", 64'(word_count), 64'd5);
        chk("t6_wrap_word_count", 64'(w_word_count), 64'd5);
        chk("t6_wrap_last_addr", 64'(w_addr), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
